booth_r4_seq_mul: RTL and testbench
===================================

// Module: booth_r4_seq_mul
// PURPOSE
// - Iterative radix-4 Booth multiplier for the core's M-extension path (MUL/MULH/MULHSU/MULHU).
// - Generalises the single-digit Booth selector: width, digits retired per cycle and signedness mode are parameters/inputs.
// - Sits behind the EX stage on a valid/ready handshake and returns the full 2*DATA_WIDTH product.
// PARAMETERS
// - DATA_WIDTH    32  operand width; must be even
// - DIGITS_PER_CYC 2  Booth digits retired per cycle; range 1..NDIG
// - NDIG = (DATA_WIDTH+2)/2 (local)  Booth digits over the extended multiplier
// - ITER = ceil(NDIG/DIGITS_PER_CYC) (local)  compute cycles; 9 at the defaults
// PORTS
// - clk        in   1             rising-edge clock
// - rst        in   1             synchronous, active-high reset
// - in_valid   in   1             operands valid
// - in_ready   out  1             block can accept; high only in IDLE
// - a_i        in   DATA_WIDTH    multiplicand
// - b_i        in   DATA_WIDTH    multiplier
// - a_signed_i in   1             1: a_i is two's complement; 0: unsigned
// - b_signed_i in   1             1: b_i is two's complement; 0: unsigned
// - flush_i    in   1             abort the current operation (pipeline flush)
// - out_valid  out  1             product valid
// - out_ready  in   1             consumer accepts the product
// - prod_o     out  2*DATA_WIDTH  full product {hi, lo}
// BEHAVIOUR
// - Clock and reset: one clock; reset is synchronous and active-high.
// - Reset values: state=IDLE, in_ready=1, out_valid=0, prod_o=0, and all internal registers cleared.
// - FSM states IDLE -> BUSY -> DONE -> IDLE.
//   - IDLE: when in_valid&&in_ready, latch the operands and go to BUSY with iteration count cnt=0.
//   - BUSY: on each cycle, retire DIGITS_PER_CYC digits and increment cnt. When cnt==ITER-1, go to DONE.
//   - DONE: out_valid=1 and prod_o is held stable. On out_ready, go to IDLE.
// - Latency: out_valid rises exactly ITER+1 clock edges after the accepting edge.
//   - out_valid stays high until out_ready is seen.
//   - The earliest next accept is on the edge after the out_ready handshake. There is no accept-while-DONE overlap.
// - Extension on latch:
//   - A_ext = DATA_WIDTH+2 bits, sign- or zero-extended per a_signed_i.
//   - B_ext = DATA_WIDTH+2 bits, extended per b_signed_i, with a 0 appended below the LSB (the Booth y[-1] bit).
// - Precomputed registers, each DATA_WIDTH+2 bits: +A, -A, +2A, -2A.
//   - Two's complement, with the wrap of -(most negative) ignored because of the 2 guard bits.
// - Digit k uses y = B_ext[2k+1:2k-1] and selects a partial product:
//   - 000, 111 -> 0
//   - 001, 010 -> +A
//   - 011 -> +2A
//   - 100 -> -2A
//   - 101, 110 -> -A
// - Each partial product is sign-extended to 2*DATA_WIDTH+4 bits and shifted left 2k bits.
//   - In a cycle, the DIGITS_PER_CYC partial products plus the accumulator are summed with a CSA tree followed by one carry-propagate add.
//   - Digits with k>=NDIG (last-iteration padding) contribute 0.
// - prod_o = accumulator[2*DATA_WIDTH-1:0]. Upper guard bits are discarded; the result is exact mod 2^(2*DATA_WIDTH) in all four modes.
// - flush_i:
//   - In BUSY or DONE, flush forces IDLE on the next edge: out_valid=0, the accumulator is cleared, and no product is emitted.
//   - In IDLE, flush_i=1 blocks acceptance that cycle; flush wins over in_valid.
// - rst asserted mid-operation behaves as flush and also clears prod_o.
// - Operands of 0 or a multiplier of all-ones still take the full ITER cycles. There is no early termination; latency is fixed.
// STRUCTURE
// - Shared package (mul_pkg): state encoding, Booth-digit codes (ZERO/POS1/POS2/NEG2/NEG1), and width helper functions (NDIG, ITER).
// - Sub-module booth_r4_pp_sel: combinational 3-bit digit -> partial-product mux with parametrised output width and shift.
//   - This module instantiates it DIGITS_PER_CYC times.
// - carry_save_adder is reused for the per-cycle compression.
// TESTING
// - Unsigned 3 x 5 -> after 10 edges, out_valid=1 and prod_o=64'h0000_0000_0000_000F.
// - Signed 0x80000000 x 0x80000000 -> prod_o=64'h4000_0000_0000_0000. Signed -1 x -1 -> 64'h0000_0000_0000_0001.
// - MULHSU: a=0xFFFFFFFF (signed) x b=0xFFFFFFFF (unsigned) -> prod_o=64'hFFFF_FFFF_0000_0001.
//   - MULHU on the same operands -> 64'hFFFF_FFFE_0000_0001.
// - Backpressure: hold out_ready=0 for 5 cycles.
//   - prod_o and out_valid stay stable and in_ready=0 throughout.
//   - After the handshake, a new op is accepted on the next edge.
// - Flush mid-op: assert flush_i at BUSY cycle 4.
//   - Next edge: IDLE, in_ready=1, and out_valid never asserts.
//   - A following 7x(-2) signed op returns 64'hFFFF_FFFF_FFFF_FFF2.
// - Sweep DIGITS_PER_CYC in {1,2,3,NDIG} at DATA_WIDTH in {8,32} against random signed/unsigned operands.
//   - Check prod_o against a reference model and latency equal to ITER+1.

Source files
------------

// File: rtl/booth_r4_seq_mul_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
//   state_e      : controller states (idle / busy / done)
//   booth_dig_e  : decoded Booth digit (0, +A, +2A, -2A, -A)
//   calc_ndig    : Booth digits needed for a DATA_WIDTH-bit operand with 2 guard bits
//   calc_iter    : compute cycles for a given digits-per-cycle
//   booth_decode : 3-bit multiplier window -> digit code
package booth_r4_seq_mul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  typedef enum logic [2:0] {
    DigZero,
    DigPos1,
    DigPos2,
    DigNeg2,
    DigNeg1
  } booth_dig_e;

  function automatic int unsigned calc_ndig(input int unsigned w);
    return (w + 2) / 2;
  endfunction

  function automatic int unsigned calc_iter(input int unsigned w, input int unsigned d);
    return (calc_ndig(w) + d - 1) / d;
  endfunction

  // Window is {y[2k+1], y[2k], y[2k-1]}.
  function automatic booth_dig_e booth_decode(input logic [2:0] y);
    booth_dig_e dig;
    unique case (y)
      3'b000, 3'b111: dig = DigZero;
      3'b001, 3'b010: dig = DigPos1;
      3'b011:         dig = DigPos2;
      3'b100:         dig = DigNeg2;
      default:        dig = DigNeg1;  // 101, 110
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_r4_pp_sel.sv
// Combinational radix-4 Booth partial-product selector.
//   i_y      : 3-bit multiplier window
//   i_en     : 0 forces a zero partial product (padding digits)
//   i_a_*    : precomputed +A, -A, +2A, -2A (IN_W bits, two's complement)
//   o_pp     : selected multiple, sign-extended to OUT_W and shifted left by SHIFT
module booth_r4_pp_sel
  import booth_r4_seq_mul_pkg::*;
#(
  parameter int unsigned IN_W  = 34,
  parameter int unsigned OUT_W = 68,
  parameter int unsigned SHIFT = 0
) (
  input  logic [2:0]       i_y,
  input  logic             i_en,
  input  logic [IN_W-1:0]  i_a_pos,
  input  logic [IN_W-1:0]  i_a_neg,
  input  logic [IN_W-1:0]  i_a2_pos,
  input  logic [IN_W-1:0]  i_a2_neg,
  output logic [OUT_W-1:0] o_pp
);

  logic [IN_W-1:0]  w_sel;
  logic [OUT_W-1:0] w_ext;

  always_comb begin
    w_sel = '0;
    if (i_en) begin
      unique case (booth_decode(i_y))
        DigPos1: w_sel = i_a_pos;
        DigPos2: w_sel = i_a2_pos;
        DigNeg2: w_sel = i_a2_neg;
        DigNeg1: w_sel = i_a_neg;
        default: w_sel = '0;
      endcase
    end
  end

  assign w_ext = {{(OUT_W - IN_W){w_sel[IN_W-1]}}, w_sel};
  assign o_pp  = w_ext << SHIFT;

endmodule

// File: rtl/carry_save_adder.sv
// 3:2 carry-save compressor.
//   i_a, i_b, i_c : addends
//   o_sum         : bitwise sum
//   o_carry       : majority carries, already shifted into their weight position
module carry_save_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH-1:0] o_carry
);

  logic [WIDTH-1:0] w_maj;

  assign o_sum   = i_a ^ i_b ^ i_c;
  assign w_maj   = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
  assign o_carry = {w_maj[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready handshakes.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (ready only while idle)
//   a_i, b_i              : multiplicand, multiplier
//   a_signed_i/b_signed_i : per-operand signedness
//   flush_i               : abort the current operation
//   out_valid / out_ready : product handshake
//   prod_o                : full 2*DATA_WIDTH product
module booth_r4_seq_mul
  import booth_r4_seq_mul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DIGITS_PER_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  input  logic                    a_signed_i,
  input  logic                    b_signed_i,
  input  logic                    flush_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] prod_o
);

  localparam int unsigned NDIG  = calc_ndig(DATA_WIDTH);
  localparam int unsigned ITER  = calc_iter(DATA_WIDTH, DIGITS_PER_CYC);
  localparam int unsigned EW    = DATA_WIDTH + 2;      // extended operand width
  localparam int unsigned AW    = 2 * DATA_WIDTH + 4;  // accumulator width
  localparam int unsigned BW    = EW + 1;              // multiplier plus the y[-1] bit
  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  state_e                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [EW-1:0]           r_a_pos, r_a_neg, r_a2_pos, r_a2_neg;
  logic [BW-1:0]           r_b;
  logic [AW-1:0]           r_acc;
  logic [2*DATA_WIDTH-1:0] r_prod;
  logic                    r_in_ready;
  logic                    r_out_valid;

  logic [EW-1:0]  w_a_ext, w_b_ext, w_a2;
  logic [15:0]    w_shamt;
  logic [AW-1:0]  w_sum;
  logic           w_dig_en [DIGITS_PER_CYC];
  logic [AW-1:0]  w_pp     [DIGITS_PER_CYC];
  logic [AW-1:0]  w_pp_sh  [DIGITS_PER_CYC];
  logic [AW-1:0]  w_csa_s  [DIGITS_PER_CYC+1];
  logic [AW-1:0]  w_csa_c  [DIGITS_PER_CYC+1];

  assign w_a_ext = {{2{a_signed_i & a_i[DATA_WIDTH-1]}}, a_i};
  assign w_b_ext = {{2{b_signed_i & b_i[DATA_WIDTH-1]}}, b_i};
  assign w_a2    = {w_a_ext[EW-2:0], 1'b0};

  // r_b is consumed from the bottom, so this cycle's first digit sits at weight 2*D*cnt.
  assign w_shamt = 16'(2 * DIGITS_PER_CYC) * 16'(r_cnt);

  assign w_csa_s[0] = r_acc;
  assign w_csa_c[0] = '0;

  for (genvar j = 0; j < int'(DIGITS_PER_CYC); j++) begin : g_dig
    // Padding digits past the top of the extended multiplier contribute nothing.
    assign w_dig_en[j] = ((32'(r_cnt) * 32'(DIGITS_PER_CYC)) + 32'(j)) < 32'(NDIG);

    booth_r4_pp_sel #(
      .IN_W (EW),
      .OUT_W(AW),
      .SHIFT(2 * j)
    ) u_pp_sel (
      .i_y     (r_b[2*j+2:2*j]),
      .i_en    (w_dig_en[j]),
      .i_a_pos (r_a_pos),
      .i_a_neg (r_a_neg),
      .i_a2_pos(r_a2_pos),
      .i_a2_neg(r_a2_neg),
      .o_pp    (w_pp[j])
    );

    assign w_pp_sh[j] = w_pp[j] << w_shamt;

    carry_save_adder #(
      .WIDTH(AW)
    ) u_csa (
      .i_a    (w_csa_s[j]),
      .i_b    (w_csa_c[j]),
      .i_c    (w_pp_sh[j]),
      .o_sum  (w_csa_s[j+1]),
      .o_carry(w_csa_c[j+1])
    );
  end

  assign w_sum = w_csa_s[DIGITS_PER_CYC] + w_csa_c[DIGITS_PER_CYC];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_a_pos     <= '0;
      r_a_neg     <= '0;
      r_a2_pos    <= '0;
      r_a2_neg    <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_prod      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid && r_in_ready && !flush_i) begin
            r_a_pos    <= w_a_ext;
            r_a_neg    <= -w_a_ext;
            r_a2_pos   <= w_a2;
            r_a2_neg   <= -w_a2;
            r_b        <= {w_b_ext, 1'b0};
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= StBusy;
          end
        end
        StBusy: begin
          if (flush_i) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
            r_state    <= StIdle;
          end else begin
            r_acc <= w_sum;
            // Arithmetic shift keeps windows past the sign bit at 000/111.
            r_b   <= BW'($signed(r_b) >>> (2 * DIGITS_PER_CYC));
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(ITER - 1)) begin
              r_state <= StDone;
            end
          end
        end
        StDone: begin
          if (flush_i) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end else if (!r_out_valid) begin
            // First DONE cycle registers the product; it then stays frozen until taken.
            r_prod      <= r_acc[2*DATA_WIDTH-1:0];
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign prod_o    = r_prod;

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
module tb_booth_r4_seq_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, a_signed, b_signed, flush, out_valid, out_ready;
  logic [31:0] a, b;
  logic [63:0] prod;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  booth_r4_seq_mul #(
    .DATA_WIDTH    (32),
    .DIGITS_PER_CYC(2)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a),
    .b_i       (b),
    .a_signed_i(a_signed),
    .b_signed_i(b_signed),
    .flush_i   (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod_o    (prod)
  );

  // Parameter sweep instances sharing one operand stream.
  function automatic int sw_w(input int g);
    return (g < 4) ? 8 : 32;
  endfunction

  function automatic int sw_d(input int g);
    case (g % 4)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return (sw_w(g) + 2) / 2;
    endcase
  endfunction

  logic        sw_in_valid;
  logic [31:0] sw_a, sw_b;
  logic        sw_as, sw_bs;
  logic        sw_in_ready [8];
  logic        sw_valid    [8];
  logic [63:0] sw_prod     [8];

  for (genvar g = 0; g < 8; g++) begin : g_sw
    localparam int W = sw_w(g);
    localparam int D = sw_d(g);
    logic [2*W-1:0] p;

    booth_r4_seq_mul #(
      .DATA_WIDTH    (W),
      .DIGITS_PER_CYC(D)
    ) u_sw (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sw_in_valid),
      .in_ready  (sw_in_ready[g]),
      .a_i       (sw_a[W-1:0]),
      .b_i       (sw_b[W-1:0]),
      .a_signed_i(sw_as),
      .b_signed_i(sw_bs),
      .flush_i   (1'b0),
      .out_valid (sw_valid[g]),
      .out_ready (1'b1),
      .prod_o    (p)
    );

    assign sw_prod[g] = 64'(p);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: extend each operand to 128 bits, multiply, keep the low 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic xs, input logic ys);
    logic signed [127:0] ex, ey, pr;
    logic [63:0] r;
    for (int i = 0; i < 128; i++) begin
      ex[i] = (i < w) ? x[i] : (xs & x[w-1]);
      ey[i] = (i < w) ? y[i] : (ys & y[w-1]);
    end
    pr = ex * ey;
    for (int i = 0; i < 64; i++) r[i] = (i < 2 * w) ? pr[i] : 1'b0;
    return r;
  endfunction

  function automatic int exp_iter(input int w, input int d);
    return ((w + 2) / 2 + d - 1) / d;
  endfunction

  task automatic wait_valid(output int lat, output logic [63:0] p);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    p = prod;
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic xs,
                        input logic ys, output logic [63:0] p, output int lat);
    @(negedge clk);
    a = x; b = y; a_signed = xs; b_signed = ys; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(lat, p);
    @(posedge clk);  // handshake with out_ready=1
    #1;
  endtask

  logic [63:0] p, p0, exp_p;
  int          lat, seen;
  logic [31:0] ra, rb;
  logic        ras, rbs;
  int          lat_s [8];
  logic [63:0] got_s [8];
  int          pending;

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0;
    sw_in_valid = 1'b0; sw_a = '0; sw_b = '0; sw_as = 1'b0; sw_bs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_prod", prod, 64'd0);

    // Directed products and latency.
    run_op(32'd3, 32'd5, 1'b0, 1'b0, p, lat);
    check_eq("u3x5", p, 64'h0000_0000_0000_000F);
    check_eq("u3x5_lat", 64'(lat), 64'd10);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, p, lat);
    check_eq("s_min_sq", p, 64'h4000_0000_0000_0000);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, p, lat);
    check_eq("s_m1_m1", p, 64'h0000_0000_0000_0001);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, p, lat);
    check_eq("mulhsu", p, 64'hFFFF_FFFF_0000_0001);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, p, lat);
    check_eq("mulhu", p, 64'hFFFF_FFFE_0000_0001);
    check_eq("mulhu_lat", 64'(lat), 64'd10);
    run_op(32'd0, 32'h1234_5678, 1'b1, 1'b1, p, lat);
    check_eq("zero_op", p, 64'd0);
    check_eq("zero_lat", 64'(lat), 64'd10);

    // Backpressure: product held, no accept until after the handshake.
    out_ready = 1'b0;
    @(negedge clk);
    a = 32'd1000; b = 32'hFFFF_FFF0; a_signed = 1'b1; b_signed = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(lat, p0);
    check_eq("bp_prod", p0, 64'hFFFF_FFFF_FFFF_C180);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_valid_hold", 64'(out_valid), 64'd1);
      check_eq("bp_prod_hold", prod, p0);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    a = 32'd2; b = 32'd3; a_signed = 1'b0; b_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_hs_valid", 64'(out_valid), 64'd0);
    check_eq("bp_hs_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("bp_accept", 64'(in_ready), 64'd0);
    wait_valid(lat, p);
    check_eq("bp_next_prod", p, 64'd6);
    check_eq("bp_next_lat", 64'(lat), 64'd10);
    @(posedge clk);
    #1;

    // Flush at BUSY cycle 4.
    @(negedge clk);
    a = 32'd12345; b = 32'd678; a_signed = 1'b1; b_signed = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_eq("flush_in_ready", 64'(in_ready), 64'd1);
    check_eq("flush_out_valid", 64'(out_valid), 64'd0);
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check_eq("flush_no_valid", 64'(seen), 64'd0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, p, lat);
    check_eq("post_flush_7xm2", p, 64'hFFFF_FFFF_FFFF_FFF2);

    // Flush in IDLE wins over in_valid.
    @(negedge clk);
    a = 32'd9; b = 32'd9; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    check_eq("idle_flush_block", 64'(in_ready), 64'd1);

    // Reset mid-operation clears the held product.
    @(negedge clk);
    a = 32'd5; b = 32'd5; a_signed = 1'b0; b_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_mid_prod", prod, 64'd0);
    check_eq("rst_mid_valid", 64'(out_valid), 64'd0);
    check_eq("rst_mid_ready", 64'(in_ready), 64'd1);

    // Random operands on the main instance.
    for (int t = 0; t < 16; t++) begin
      ra = $urandom; rb = $urandom;
      ras = 1'($urandom_range(0, 1)); rbs = 1'($urandom_range(0, 1));
      run_op(ra, rb, ras, rbs, p, lat);
      check_eq("rand_prod", p, ref_mul(32, ra, rb, ras, rbs));
      check_eq("rand_lat", 64'(lat), 64'd10);
    end

    // Width / digits-per-cycle sweep.
    for (int t = 0; t < 12; t++) begin
      ra = $urandom; rb = $urandom;
      if (t == 0) ra = '0;
      if (t == 1) rb = '1;
      if (t == 2) begin ra = 32'h8000_0080; rb = 32'h8000_0080; end
      ras = 1'($urandom_range(0, 1)); rbs = 1'($urandom_range(0, 1));
      @(negedge clk);
      sw_a = ra; sw_b = rb; sw_as = ras; sw_bs = rbs; sw_in_valid = 1'b1;
      @(posedge clk);
      #1;
      sw_in_valid = 1'b0;
      for (int g = 0; g < 8; g++) begin
        lat_s[g] = -1;
        got_s[g] = 'x;
      end
      for (int n = 1; n <= 40; n++) begin
        @(posedge clk);
        #1;
        pending = 0;
        for (int g = 0; g < 8; g++) begin
          if (lat_s[g] < 0) begin
            if (sw_valid[g]) begin
              lat_s[g] = n;
              got_s[g] = sw_prod[g];
            end else begin
              pending++;
            end
          end
        end
        if (pending == 0) break;
      end
      for (int g = 0; g < 8; g++) begin
        exp_p = ref_mul(sw_w(g), ra, rb, ras, rbs);
        check_eq($sformatf("sw_prod_w%0d_d%0d", sw_w(g), sw_d(g)), got_s[g], exp_p);
        check_eq($sformatf("sw_lat_w%0d_d%0d", sw_w(g), sw_d(g)), 64'(lat_s[g]),
                 64'(exp_iter(sw_w(g), sw_d(g)) + 1));
      end
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
